// File: rtl/tero_pkg.sv
// tero_pkg: shared types and default constants for the TERO measurement controller
package tero_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, RUN, DRAIN, REPORT} tero_meas_state_t;
  localparam int TERO_N_TERO_BITS   = 32;
  localparam int TERO_CNT_BITS      = 16;
  localparam int TERO_N_PAIRS       = 16;
  localparam int TERO_SETTLE_CYCLES = 4;
  localparam int TERO_WINDOW_CYCLES = 1024;
  localparam int TERO_SYNC_DEPTH    = 2;
  localparam int TERO_DRAIN_CYCLES  = 2;
endpackage

// File: rtl/tero_edge_sync.sv
// tero_edge_sync: synchronizes the async oscillator and flags its rising edges
// Ports: clk, reset (sync, active-high), osc_in (async), edge_pulse (one cycle per rising edge)
module tero_edge_sync
  import tero_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic osc_in,
  output logic edge_pulse
);
  logic [TERO_SYNC_DEPTH-1:0] sync;
  logic prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[TERO_SYNC_DEPTH-2:0], osc_in};
      prev <= sync[TERO_SYNC_DEPTH-1];
    end
  end
  assign edge_pulse = sync[TERO_SYNC_DEPTH-1] & ~prev;
endmodule

// File: rtl/tero_measure_ctrl.sv
// tero_measure_ctrl: sweeps TERO pairs, counts oscillator edges per window, emits pair response bits
// Ports: clk, reset (sync, active-high), start, tero_idx, osc_in (async) in;
//        idx_clear, increment, tero_en, busy, count, count_idx, count_valid,
//        resp_bit, resp_valid, done out.
// Build option: TERO_CNT_SAT_EN makes the edge counter saturate instead of wrap.
module tero_measure_ctrl
  import tero_pkg::*;
#(
  parameter int N_TERO_BITS   = TERO_N_TERO_BITS,
  parameter int CNT_BITS      = TERO_CNT_BITS,
  parameter int N_PAIRS       = TERO_N_PAIRS,
  parameter int SETTLE_CYCLES = TERO_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = TERO_WINDOW_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_TERO_BITS-1:0] tero_idx,
  input  logic                   osc_in,
  output logic                   idx_clear,
  output logic                   increment,
  output logic                   tero_en,
  output logic                   busy,
  output logic [CNT_BITS-1:0]    count,
  output logic [N_TERO_BITS-1:0] count_idx,
  output logic                   count_valid,
  output logic                   resp_bit,
  output logic                   resp_valid,
  output logic                   done
);
  localparam int TW = $clog2(WINDOW_CYCLES > SETTLE_CYCLES ? WINDOW_CYCLES : SETTLE_CYCLES) + 1;
  localparam int PW = $clog2(N_PAIRS) + 1;
  tero_meas_state_t state, state_nx;
  logic [TW-1:0] tmr;
  logic [PW-1:0] pair;
  logic flag;
  logic [CNT_BITS-1:0] cnt, cnt_a, cnt_inc, count_q;
  logic [N_TERO_BITS-1:0] idx_q, count_idx_q;
  logic resp_q, edge_pulse, settle_end, run_end, drain_end, last, report, cnt_en;
  tero_edge_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .osc_in    (osc_in),
    .edge_pulse(edge_pulse)
  );
`ifdef TERO_CNT_SAT_EN
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
`else
  assign cnt_inc = cnt + 1'b1;
`endif
  assign settle_end = tmr == TW'(SETTLE_CYCLES - 1);
  assign run_end    = tmr == TW'(WINDOW_CYCLES - 1);
  assign drain_end  = tmr == TW'(TERO_DRAIN_CYCLES - 1);
  assign last       = flag && pair == PW'(N_PAIRS - 1);
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx    = state;
    report      = state == REPORT;
    cnt_en      = state == RUN || state == DRAIN;
    idx_clear   = state == IDLE && start && !reset;
    increment   = report;
    count_valid = report;
    resp_valid  = report && flag;
    done        = report && last;
    tero_en     = state == RUN;
    busy        = state != IDLE;
    count       = report ? cnt : count_q;
    count_idx   = report ? idx_q : count_idx_q;
    resp_bit    = report && flag ? cnt_a > cnt : resp_q;
    case (state)
      IDLE:    state_nx = start ? SETTLE : IDLE;
      SETTLE:  state_nx = settle_end ? RUN : SETTLE;
      RUN:     state_nx = run_end ? DRAIN : RUN;
      DRAIN:   state_nx = drain_end ? REPORT : DRAIN;
      REPORT:  state_nx = last ? IDLE : SETTLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr         <= '0;
      pair        <= '0;
      flag        <= 1'b0;
      cnt         <= '0;
      cnt_a       <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      count_idx_q <= '0;
      resp_q      <= 1'b0;
    end else begin
      tmr <= (state_nx != state || state == IDLE) ? '0 : tmr + 1'b1;
      if (idx_clear) begin
        pair <= '0;
        flag <= 1'b0;
      end
      // the counter starts fresh right before the window; edges are still absorbed through DRAIN
      if (state == SETTLE && settle_end) begin
        cnt   <= '0;
        idx_q <= tero_idx;
      end else if (cnt_en && edge_pulse) cnt <= cnt_inc;
      if (report) begin
        count_q     <= cnt;
        count_idx_q <= idx_q;
        flag        <= ~flag;
        if (!flag) cnt_a <= cnt;
        else begin
          resp_q <= cnt_a > cnt;
          pair   <= pair + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tero_measure_ctrl.sv
// tb_tero_measure_ctrl: directed table-driven checks of the TERO measurement controller
module tb_tero_measure_ctrl;
  logic clk = 0, reset, start, start_s;
  logic [31:0] tero_idx = 0, tero_idx_s = 0, count_idx, count_idx_s;
  logic osc = 0, osc_s = 0;
  logic idx_clear, increment, tero_en, busy, count_valid, resp_bit, resp_valid, done;
  logic idx_clear_s, increment_s, tero_en_s, busy_s, count_valid_s, resp_bit_s, resp_valid_s, done_s;
  logic [15:0] count;
  logic [3:0] count_s;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int n_cv = 0, n_inc = 0, n_rv = 0, n_done = 0, n_clr = 0;
  int ph = 0, ph_s = 0, p;
  int t0, s_cv, s_inc, s_rv, s_done, s_clr;
  bit ok;
  typedef struct {int period; int exp_count; bit exp_rv; bit exp_resp;} vec_t;
  vec_t vec[8];
  localparam logic [3:0] SAT_EXP =
`ifdef TERO_CNT_SAT_EN
    4'd15;
`else
    4'd0;
`endif
  tero_measure_ctrl #(.N_TERO_BITS(32), .CNT_BITS(16), .N_PAIRS(4), .SETTLE_CYCLES(4), .WINDOW_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .start(start), .tero_idx(tero_idx), .osc_in(osc),
    .idx_clear(idx_clear), .increment(increment), .tero_en(tero_en), .busy(busy),
    .count(count), .count_idx(count_idx), .count_valid(count_valid),
    .resp_bit(resp_bit), .resp_valid(resp_valid), .done(done));
  tero_measure_ctrl #(.N_TERO_BITS(32), .CNT_BITS(4), .N_PAIRS(1), .SETTLE_CYCLES(4), .WINDOW_CYCLES(64)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .tero_idx(tero_idx_s), .osc_in(osc_s),
    .idx_clear(idx_clear_s), .increment(increment_s), .tero_en(tero_en_s), .busy(busy_s),
    .count(count_s), .count_idx(count_idx_s), .count_valid(count_valid_s),
    .resp_bit(resp_bit_s), .resp_valid(resp_valid_s), .done(done_s));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tero_idx <= idx_clear ? 0 : increment ? tero_idx + 1 : tero_idx;
  always @(posedge clk) tero_idx_s <= idx_clear_s ? 0 : increment_s ? tero_idx_s + 1 : tero_idx_s;
  always @(posedge clk) begin
    #1;
    if (tero_en) begin
      p = tero_idx < 8 ? vec[tero_idx].period : 0;
      osc = p != 0 && (ph % p) >= p / 2;
      ph++;
    end else begin
      osc = 0;
      ph = 0;
    end
    osc_s = tero_en_s && (ph_s % 4) >= 2;
    ph_s = tero_en_s ? ph_s + 1 : 0;
  end
  always @(negedge clk) begin
    if (count_valid) n_cv++;
    if (increment) n_inc++;
    if (resp_valid) n_rv++;
    if (done) n_done++;
    if (idx_clear) n_clr++;
  end
  wire [63:0] outs = {idx_clear, increment, tero_en, busy, count, count_idx, count_valid, resp_bit, resp_valid, done};
  wire [63:0] outs_s = {idx_clear_s, increment_s, tero_en_s, busy_s, count_s, count_idx_s, count_valid_s, resp_bit_s, resp_valid_s, done_s};
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic go(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic wait_cv(input bit s, output bit found);
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s ? count_valid_s : count_valid) begin
        found = 1;
        break;
      end
    end
    if (!found) chk("count_valid_timeout", 0, 1);
  endtask
  initial begin
    vec[0] = '{8, 8, 0, 0};
    vec[1] = '{16, 4, 1, 1};
    vec[2] = '{0, 0, 0, 0};
    vec[3] = '{0, 0, 1, 0};
    vec[4] = '{16, 4, 0, 0};
    vec[5] = '{8, 8, 1, 0};
    vec[6] = '{4, 16, 0, 0};
    vec[7] = '{4, 16, 1, 0};
    reset = 1; start = 0; start_s = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 0);
    chk("reset_outs_s", outs_s, 0);
    start = 1;
    #1 chk("reset_start_no_clear", idx_clear, 0);
    @(negedge clk);
    start = 0; reset = 0;
    chk("reset_start_idle", busy, 0);
    @(negedge clk);
    s_cv = n_cv; s_inc = n_inc; s_rv = n_rv; s_done = n_done; s_clr = n_clr;
    start = 1; t0 = cyc;
    #1 chk("idx_clear_cycle0", idx_clear, 1);
    go(t0 + 1);
    start = 0;
    chk("busy_settle", busy, 1);
    chk("tero_idx_cleared", tero_idx, 0);
    go(t0 + 4);
    chk("tero_en_last_settle", tero_en, 0);
    go(t0 + 5);
    chk("tero_en_first_run", tero_en, 1);
    go(t0 + 20);
    start = 1;
    go(t0 + 21);
    start = 0;
    go(t0 + 68);
    chk("tero_en_last_run", tero_en, 1);
    go(t0 + 69);
    chk("tero_en_drain", tero_en, 0);
    for (int m = 0; m < 8; m++) begin
      wait_cv(0, ok);
      if (ok) begin
        chk($sformatf("report_cycle_%0d", m), cyc - t0, (m + 1) * 71);
        chk($sformatf("count_%0d", m), count, vec[m].exp_count);
        chk($sformatf("count_idx_%0d", m), count_idx, m);
        chk($sformatf("increment_%0d", m), increment, 1);
        chk($sformatf("resp_valid_%0d", m), resp_valid, vec[m].exp_rv);
        if (vec[m].exp_rv) chk($sformatf("resp_bit_%0d", m), resp_bit, vec[m].exp_resp);
        chk($sformatf("done_%0d", m), done, m == 7);
        @(negedge clk);
        chk($sformatf("count_hold_%0d", m), count, vec[m].exp_count);
        chk($sformatf("count_idx_hold_%0d", m), count_idx, m);
        if (vec[m].exp_rv) chk($sformatf("resp_hold_%0d", m), resp_bit, vec[m].exp_resp);
      end
    end
    chk("idle_after_done", busy, 0);
    chk("n_count_valid", n_cv - s_cv, 8);
    chk("n_increment", n_inc - s_inc, 8);
    chk("n_resp_valid", n_rv - s_rv, 4);
    chk("n_done", n_done - s_done, 1);
    chk("n_idx_clear", n_clr - s_clr, 1);
    @(negedge clk);
    start = 1; t0 = cyc;
    go(t0 + 1);
    start = 0;
    go(t0 + 34);
    chk("run_before_reset", tero_en, 1);
    reset = 1;
    go(t0 + 35);
    reset = 0;
    chk("midrun_reset_outs", outs, 0);
    s_cv = n_cv;
    go(t0 + 120);
    chk("midrun_no_count_valid", n_cv - s_cv, 0);
    chk("midrun_idle", busy, 0);
    start = 1; t0 = cyc;
    go(t0 + 1);
    start = 0;
    wait_cv(0, ok);
    if (ok) begin
      chk("restart_report_cycle", cyc - t0, 71);
      chk("restart_count", count, 8);
      chk("restart_count_idx", count_idx, 0);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    start_s = 1; t0 = cyc;
    go(t0 + 1);
    start_s = 0;
    wait_cv(1, ok);
    if (ok) begin
      chk("sat_report_a_cycle", cyc - t0, 71);
      chk("sat_count_a", count_s, SAT_EXP);
      chk("sat_resp_valid_a", resp_valid_s, 0);
    end
    wait_cv(1, ok);
    if (ok) begin
      chk("sat_done_cycle", cyc - t0, 142);
      chk("sat_count_b", count_s, SAT_EXP);
      chk("sat_resp_valid_b", resp_valid_s, 1);
      chk("sat_resp_tie", resp_bit_s, 0);
      chk("sat_done", done_s, 1);
      chk("sat_count_idx_b", count_idx_s, 1);
    end
    @(negedge clk);
    chk("sat_idle", busy_s, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tero_measure_ctrl.md
# tero_measure_ctrl

Measurement controller that sits directly downstream of the TERO index counter in the PUF datapath. It sweeps a configurable number of TERO pairs. For each TERO it excites the selected oscillator for a fixed window and counts its synchronized rising edges. It compares the two counts of each pair to emit one response bit, and pulses `increment` so the upstream counter advances to the next TERO index.

## Interface
- `N_TERO_BITS`, 32, width of the TERO index from the upstream counter
- `CNT_BITS`, 16, edge-counter width
- `N_PAIRS`, 16, pairs measured per run (2·N_PAIRS TEROs)
- `SETTLE_CYCLES`, 4, idle cycles before each window for index/mux settling (≥2)
- `WINDOW_CYCLES`, 1024, cycles `tero_en` is held high per measurement
- `clk  in  1  system clock`
- `reset  in  1  reset, synchronous, active-high`
- `start  in  1  begin a run; sampled only in IDLE`
- `tero_idx  in  N_TERO_BITS  current index from upstream counter (informational, echoed on count_idx)`
- `osc_in  in  1  selected TERO output, asynchronous to clk`
- `idx_clear  out  1  one-cycle pulse driving upstream counter reset`
- `increment  out  1  one-cycle pulse advancing upstream counter`
- `tero_en  out  1  excitation/enable of the selected TERO`
- `busy  out  1  high in every state except IDLE`
- `count  out  CNT_BITS  last measured edge count`
- `count_idx  out  N_TERO_BITS  tero_idx latched at the measured TERO's RUN entry`
- `count_valid  out  1  one-cycle strobe, count/count_idx valid`
- `resp_bit  out  1  pair response: 1 iff count_A > count_B`
- `resp_valid  out  1  one-cycle strobe for resp_bit`
- `done  out  1  one-cycle pulse at end of run`

## Operation
- States: IDLE, SETTLE, RUN, DRAIN, REPORT.
- IDLE: `start`=1 → pulse `idx_clear`, clear the pair counter and the A/B flag, then go to SETTLE.
- SETTLE: hold for SETTLE_CYCLES with `tero_en`=0. The edge counter clears on the last SETTLE cycle, and `count_idx` is latched at the same time.
- RUN: hold for WINDOW_CYCLES with `tero_en`=1 and counting enabled.
- DRAIN: 2 cycles with `tero_en`=0. Counting stays enabled to flush the synchronizer.
- REPORT: 1 cycle. `count_valid`=1 and `increment`=1.
  - Measurement A: store the count and set the flag.
  - Measurement B: `resp_bit`=(A>B), `resp_valid`=1, pair counter +1.
  - After B of pair N_PAIRS-1: `done`=1, next state IDLE. Otherwise next state SETTLE.
- Edge counting: `osc_in` passes through a 2-flop synchronizer plus a previous-value register. A rising edge is sync=1, prev=0; each edge adds 1.
- Oscillation at or above clk/2 is undercounted; this is a documented limitation, not an error.
- Tie (A==B) gives `resp_bit`=0.
- `start` while busy is ignored.
- Simultaneous `reset` and `start`: reset wins.
- Reset mid-run: state IDLE; all outputs 0; counters, stored A and flag cleared. Partial results are discarded, with no `count_valid`, `resp_valid` or `done` pulse.
- Reset value of every output is 0.

## Timing
- Start accepted in cycle 0. `idx_clear` is high in cycle 0. `tero_idx` is 0 from cycle 1, and SETTLE occupies cycles 1..S.
- RUN occupies S+1..S+W; DRAIN occupies S+W+1..S+W+2; REPORT is cycle S+W+3.
- Per-measurement period P = S+W+3 (SETTLE through REPORT).
- `resp_valid` fires every second REPORT.
- `done` fires in cycle 2·N_PAIRS·P.
- `count`, `count_idx` and `resp_bit` hold their values until the next REPORT.
- Upstream latency: `increment` in REPORT updates `tero_idx` one cycle later, which falls inside the following SETTLE.

## Configuration
- `TERO_CNT_SAT_EN` defined: the edge counter saturates at 2^CNT_BITS-1 and holds.
- Undefined: the edge counter wraps modulo 2^CNT_BITS.
- The comparison uses the stored value in both cases.

## Structure
- Package `tero_pkg` holds:
  - state enum `tero_meas_state_t`
  - default parameter constants
  - synchronizer depth constant (2)
- Sub-module `tero_edge_sync` holds the 2-flop synchronizer and rising-edge detector. Its output is a one-cycle `edge` pulse, and it is reset by `reset`.

## Test plan
- S=4, W=64, N_PAIRS=1; `osc_in` square wave period 8 clk for A and period 16 clk for B → A count ∈ {7,8,9}, B count ∈ {3,4,5}; `resp_bit`=1, `resp_valid` and `done` in cycle 2·71=142.
- `osc_in` held at 0 for both TEROs → both counts 0, `resp_bit`=0 (tie); 2 `increment` pulses; one `idx_clear` at start.
- `reset` asserted in cycle 30 of RUN → next cycle all outputs 0, state IDLE; no `count_valid`; a new `start` yields the normal sequence.
- `start` pulsed during RUN → ignored; timing of the current run is unchanged.
- CNT_BITS=4, W=64, period-2-cycle-safe input (period 4 clk) → with `TERO_CNT_SAT_EN`: count=15; without: count=16 mod 16=0.
- N_PAIRS=4 → exactly 8 `count_valid`, 8 `increment`, 4 `resp_valid`, 1 `done`; `count_idx` sequence 0..7 using the upstream counter model.
